// File: rtl/pipe_pkg.sv
// Shared ID/EX pipeline definitions: ALUOp and funct codes, ALU select encodings
// and the control bundle that travels from ID into EX.
package pipe_pkg;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OP_RSVD  = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [1:0] SEL_AND    = 2'b00;
    localparam logic [1:0] SEL_OR     = 2'b01;
    localparam logic [1:0] SEL_ADDSUB = 2'b10;
    localparam logic [1:0] SEL_SLT    = 2'b11;

    typedef struct packed {
        logic       valid;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       aluSrc;
        logic [1:0] aluSel;
        logic       invertB;
        logic       cin;
        logic       illegal;
    } idExCtrl_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side operands and control, EX/MEM and MEM/WB forwarding
// sources, and the registered EX-side outputs.
interface id_ex_stage_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RA    = 5
);
    logic             id_valid;
    logic [WIDTH-1:0] id_rs_data;
    logic [WIDTH-1:0] id_rt_data;
    logic [WIDTH-1:0] id_imm;
    logic [RA-1:0]    id_rs;
    logic [RA-1:0]    id_rt;
    logic [RA-1:0]    id_rd;
    logic [1:0]       id_alu_op;
    logic [5:0]       id_funct;
    logic             id_alu_src;
    logic             id_reg_dst;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             id_mem_write;
    logic             id_mem_to_reg;
    logic             flush;
    logic             exm_reg_write;
    logic [RA-1:0]    exm_rd;
    logic [WIDTH-1:0] exm_result;
    logic             mwb_reg_write;
    logic [RA-1:0]    mwb_rd;
    logic [WIDTH-1:0] mwb_result;

    logic             load_use_stall;
    logic             ex_valid;
    logic [WIDTH-1:0] ex_data_a;
    logic [WIDTH-1:0] ex_data_b;
    logic [WIDTH-1:0] ex_store_data;
    logic [1:0]       ex_alu_sel;
    logic             ex_invert_b;
    logic             ex_cin;
    logic [RA-1:0]    ex_dest;
    logic             ex_reg_write;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_mem_to_reg;
    logic             ex_illegal;

    modport master (
        output id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_alu_op, id_funct, id_alu_src, id_reg_dst, id_reg_write,
               id_mem_read, id_mem_write, id_mem_to_reg, flush,
               exm_reg_write, exm_rd, exm_result, mwb_reg_write, mwb_rd, mwb_result,
        input  load_use_stall, ex_valid, ex_data_a, ex_data_b, ex_store_data,
               ex_alu_sel, ex_invert_b, ex_cin, ex_dest, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal
    );

    modport slave (
        input  id_valid, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd,
               id_alu_op, id_funct, id_alu_src, id_reg_dst, id_reg_write,
               id_mem_read, id_mem_write, id_mem_to_reg, flush,
               exm_reg_write, exm_rd, exm_result, mwb_reg_write, mwb_rd, mwb_result,
        output load_use_stall, ex_valid, ex_data_a, ex_data_b, ex_store_data,
               ex_alu_sel, ex_invert_b, ex_cin, ex_dest, ex_reg_write,
               ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_illegal
    );
endinterface

// File: rtl/alu_ctrl.sv
// Combinational ALUOp/funct decode into the bit-sliced ALU's select, invert-B
// and carry-in controls, flagging unrecognised R-type functs.
module alu_ctrl
    import pipe_pkg::*;
(
    input  logic [1:0] aluOp,
    input  logic [5:0] funct,
    output logic [1:0] sel,
    output logic       invertB,
    output logic       cin,
    output logic       illegal
);

    always_comb begin
        sel     = SEL_ADDSUB;
        invertB = 1'b0;
        cin     = 1'b0;
        illegal = 1'b0;
        unique case (aluOp)
            ALU_OP_ADD, ALU_OP_RSVD: ;
            ALU_OP_SUB: begin
                invertB = 1'b1;
                cin     = 1'b1;
            end
            ALU_OP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: ;
                    FUNCT_SUB: begin
                        invertB = 1'b1;
                        cin     = 1'b1;
                    end
                    FUNCT_AND: sel = SEL_AND;
                    FUNCT_OR:  sel = SEL_OR;
                    FUNCT_SLT: begin
                        sel     = SEL_SLT;
                        invertB = 1'b1;
                        cin     = 1'b1;
                    end
                    // Unknown funct still executes as an add so EX has defined behaviour.
                    default:   illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX/MEM and MEM/WB
// operand forwarding, and registered ALU control decode.
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RA    = 5
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);

    idExCtrl_t        ctrlQ, ctrlD;
    logic [WIDTH-1:0] rsDataQ, rtDataQ, immQ;
    logic [RA-1:0]    rsQ, rtQ, destQ, destD;
    logic [1:0]       aluSel;
    logic             invertB, cin, illegal;
    logic             loadUseStall;
    logic [WIDTH-1:0] fwdA, fwdB;

    alu_ctrl uAluCtrl (
        .aluOp   (bus.id_alu_op),
        .funct   (bus.id_funct),
        .sel     (aluSel),
        .invertB (invertB),
        .cin     (cin),
        .illegal (illegal)
    );

    assign loadUseStall = bus.id_valid && ctrlQ.valid && ctrlQ.memRead && (destQ != '0) &&
                          ((destQ == bus.id_rs) || (destQ == bus.id_rt));
    assign destD = bus.id_reg_dst ? bus.id_rd : bus.id_rt;

    // Flush and stall both load a bubble; operand fields are captured regardless.
    always_comb begin
        ctrlD = '0;
        if (!(bus.flush || loadUseStall)) begin
            ctrlD.valid    = bus.id_valid;
            ctrlD.regWrite = bus.id_reg_write;
            ctrlD.memRead  = bus.id_mem_read;
            ctrlD.memWrite = bus.id_mem_write;
            ctrlD.memToReg = bus.id_mem_to_reg;
            ctrlD.aluSrc   = bus.id_alu_src;
            ctrlD.aluSel   = aluSel;
            ctrlD.invertB  = invertB;
            ctrlD.cin      = cin;
            ctrlD.illegal  = illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrlQ   <= '0;
            rsDataQ <= '0;
            rtDataQ <= '0;
            immQ    <= '0;
            rsQ     <= '0;
            rtQ     <= '0;
            destQ   <= '0;
        end else begin
            ctrlQ   <= ctrlD;
            rsDataQ <= bus.id_rs_data;
            rtDataQ <= bus.id_rt_data;
            immQ    <= bus.id_imm;
            rsQ     <= bus.id_rs;
            rtQ     <= bus.id_rt;
            destQ   <= destD;
        end
    end

    // EX/MEM is the younger producer, so it wins over MEM/WB; $0 is never forwarded.
    always_comb begin
        fwdA = rsDataQ;
        if (bus.exm_reg_write && (bus.exm_rd != '0) && (bus.exm_rd == rsQ)) begin
            fwdA = bus.exm_result;
        end else if (bus.mwb_reg_write && (bus.mwb_rd != '0) && (bus.mwb_rd == rsQ)) begin
            fwdA = bus.mwb_result;
        end
        fwdB = rtDataQ;
        if (bus.exm_reg_write && (bus.exm_rd != '0) && (bus.exm_rd == rtQ)) begin
            fwdB = bus.exm_result;
        end else if (bus.mwb_reg_write && (bus.mwb_rd != '0) && (bus.mwb_rd == rtQ)) begin
            fwdB = bus.mwb_result;
        end
    end

    assign bus.load_use_stall = loadUseStall;
    assign bus.ex_valid       = ctrlQ.valid;
    assign bus.ex_data_a      = fwdA;
    assign bus.ex_store_data  = fwdB;
    assign bus.ex_data_b      = ctrlQ.aluSrc ? immQ : fwdB;
    assign bus.ex_alu_sel     = ctrlQ.aluSel;
    assign bus.ex_invert_b    = ctrlQ.invertB;
    assign bus.ex_cin         = ctrlQ.cin;
    assign bus.ex_dest        = destQ;
    assign bus.ex_reg_write   = ctrlQ.regWrite;
    assign bus.ex_mem_read    = ctrlQ.memRead;
    assign bus.ex_mem_write   = ctrlQ.memWrite;
    assign bus.ex_mem_to_reg  = ctrlQ.memToReg;
    assign bus.ex_illegal     = ctrlQ.illegal;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the EX-stage ALU (bit-sliced ALU with 2-bit select, invert-B and carry-in).
- Registers decoded operands and control from ID.
- Detects load-use hazards and inserts bubbles.
- Resolves EX/MEM and MEM/WB forwarding.
- Decodes ALUOp/funct into the ALU's Sel, InvertB and Cin controls.

## Interface
Parameters:
- WIDTH, 32, datapath width
- RA, 5, register-address width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs_data, id_rt_data  in  WIDTH  register-file read data
- id_imm  in  WIDTH  sign-extended immediate
- id_rs, id_rt, id_rd  in  RA  register specifiers
- id_alu_op  in  2  00 add, 01 sub, 10 R-type (use funct), 11 reserved (add)
- id_funct  in  6  R-type function field
- id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  main-control bits
- flush  in  1  kill the instruction entering EX (taken branch)
- exm_reg_write  in  1  EX/MEM write enable
- exm_rd  in  RA  EX/MEM destination
- exm_result  in  WIDTH  EX/MEM ALU result
- mwb_reg_write  in  1  MEM/WB write enable
- mwb_rd  in  RA  MEM/WB destination
- mwb_result  in  WIDTH  MEM/WB write-back value
- load_use_stall  out  1  combinational; upstream holds PC and IF/ID while high
- ex_valid  out  1  EX holds a real instruction
- ex_data_a, ex_data_b  out  WIDTH  ALU operands
- ex_store_data  out  WIDTH  forwarded rt value for stores
- ex_alu_sel  out  2  00 AND, 01 OR, 10 add/sub, 11 SLT
- ex_invert_b, ex_cin  out  1  ALU subtract controls
- ex_dest  out  RA  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  control passed downstream
- ex_illegal  out  1  R-type funct not recognised

## Operation
- **Load-use detection:** load_use_stall = id_valid & ex_valid & ex_mem_read & ex_dest!=0 & (ex_dest==id_rs | ex_dest==id_rt).
- **Register update priority:** each edge, flush > load_use_stall > normal.
  - flush or load_use_stall: load a bubble (valid and all control bits 0, data don't-care).
  - Normal: capture all ID fields.
- **Destination:** ex_dest is latched as id_reg_dst ? id_rd : id_rt.
- **ALU decode**, registered from alu_op/funct:
  - add 100000 or alu_op 00/11: sel 10, inv 0, cin 0.
  - sub 100010 or alu_op 01: sel 10, inv 1, cin 1.
  - and 100100: sel 00.
  - or 100101: sel 01.
  - slt 101010: sel 11, inv 1, cin 1.
  - Unknown funct: add encoding with ex_illegal=1.
- **Forwarding**, combinational from registered fields:
  - A from rs: exm_result if exm_reg_write & exm_rd!=0 & exm_rd==ex_rs; else mwb_result if the same conditions hold for MEM/WB; else latched rs_data.
  - EX/MEM has priority over MEM/WB.
  - Same selection for rt, producing ex_store_data.
  - ex_data_b = ex_alu_src ? latched imm : ex_store_data.
- **Register 0:** never forwarded.
- **Bubbles:** forwarding logic still evaluates, but all downstream side-effect controls are 0.

## Timing
- Reset (async assert, sync-to-clk deassert by the surrounding reset tree): ex_valid, all control outputs, ex_alu_sel, ex_invert_b, ex_cin, ex_illegal and ex_dest are 0.
  - Latched data is 0, so ex_data_a/b read 0 unless forwarded.
- Latency: ID inputs appear on EX outputs one cycle after the capturing edge.
- Forwarding path is zero-cycle: the exm_/mwb_ inputs of the current cycle affect ex_data_* in the same cycle.
- load_use_stall is high for exactly one cycle per load-use pair.
  - The bubble it inserts clears ex_mem_read, so the next cycle deasserts it.
  - The ID instruction re-presents and is then captured.
- Reset mid-operation drops the in-flight instruction; nothing is replayed.

## Structure
- Shared package `pipe_pkg`:
  - ALUOp codes, funct constants, Sel encodings (SEL_AND/OR/ADDSUB/SLT).
  - ID/EX control struct type.
- Sub-module `alu_ctrl`: purely combinational ALUOp/funct to {sel, invert_b, cin, illegal} decode, instantiated once ahead of the register.
- Forwarding muxes and hazard compare live in the top module.

## Test plan
- **Reset / first capture:** rst_n low mid-stream → all outputs 0 immediately. After release, id sub $3=$1-$2 (rs_data 9, rt_data 4) → next cycle ex_alu_sel=10, inv=1, cin=1, ex_data_a=9, ex_data_b=4, ex_dest=3.
- **Decode sweep:** funct and/or/slt/unknown 0x3F → sel 00/01/11 and 10 with ex_illegal=1. alu_op 00 with alu_src=1, imm=-8 → ex_data_b=0xFFFFFFF8.
- **Forwarding:**
  - exm_rd=ex_rs=5, exm_result=0x11, and simultaneously mwb_rd=5, mwb_result=0x22 → ex_data_a=0x11.
  - With only the MEM/WB match → 0x22.
  - With rd=0 on both paths → latched value.
- **Load-use:** lw $4 in EX, ID add uses rt=4 → load_use_stall=1 for one cycle, then ex_valid=0 with controls 0, then the add is captured and load_use_stall=0.
- **Flush versus stall:** flush together with a load-use condition → bubble loaded, ex_reg_write=0. Flush asserted with a normal instruction → ex_valid=0 next cycle.
